// File: rtl/axis_frame_len_stats_if.sv
// axis_frame_len_stats_if: per-frame length strobe from the frame length monitor
interface axis_frame_len_stats_if #(parameter int LEN_WIDTH = 16);
   logic [LEN_WIDTH-1:0] frame_len;
   logic                 frame_len_valid;
   modport master (output frame_len, frame_len_valid);
   modport slave  (input  frame_len, frame_len_valid);
endinterface

// File: rtl/axis_frame_len_stats.sv
// axis_frame_len_stats: accumulates per-interval frame length statistics with snapshot/clear
module axis_frame_len_stats #(
   parameter int LEN_WIDTH        = 16,
   parameter int COUNT_WIDTH      = 32,
   parameter int BYTE_COUNT_WIDTH = 48,
   parameter int RUNT_LEN         = 64,
   parameter int MAX_LEN          = 1518
) (
   input  logic                        clk,
   input  logic                        rst,
   axis_frame_len_stats_if.slave       fl,
   input  logic                        clear,
   input  logic                        snapshot,
   output logic [COUNT_WIDTH-1:0]      stat_frame_count,
   output logic [BYTE_COUNT_WIDTH-1:0] stat_byte_count,
   output logic [LEN_WIDTH-1:0]        stat_min_len,
   output logic [LEN_WIDTH-1:0]        stat_max_len,
   output logic [COUNT_WIDTH-1:0]      stat_runt_count,
   output logic [COUNT_WIDTH-1:0]      stat_oversize_count,
   output logic                        stat_valid
);
   localparam logic [LEN_WIDTH:0] RUNT = (LEN_WIDTH+1)'(RUNT_LEN);
   localparam logic [LEN_WIDTH:0] OVER = (LEN_WIDTH+1)'(MAX_LEN);
   logic [COUNT_WIDTH-1:0]      cnt, runt, over, cnt_n, runt_n, over_n;
   logic [BYTE_COUNT_WIDTH-1:0] bytes, bytes_n;
   logic [BYTE_COUNT_WIDTH:0]   byte_sum;
   logic [LEN_WIDTH-1:0]        min_l, max_l, min_n, max_n;
   logic                        v, is_runt, is_over;
   // live values including this cycle's strobe; snapshot latches these directly
   always_comb begin
      v        = fl.frame_len_valid;
      is_runt  = {1'b0, fl.frame_len} < RUNT;
      is_over  = {1'b0, fl.frame_len} > OVER;
      byte_sum = {1'b0, bytes} + (BYTE_COUNT_WIDTH+1)'(fl.frame_len);
      cnt_n    = v && !(&cnt) ? cnt + 1'b1 : cnt;
      runt_n   = v && is_runt && !(&runt) ? runt + 1'b1 : runt;
      over_n   = v && is_over && !(&over) ? over + 1'b1 : over;
      bytes_n  = !v ? bytes : byte_sum[BYTE_COUNT_WIDTH] ? '1 : byte_sum[BYTE_COUNT_WIDTH-1:0];
      min_n    = v && fl.frame_len < min_l ? fl.frame_len : min_l;
      max_n    = v && fl.frame_len > max_l ? fl.frame_len : max_l;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         {cnt, runt, over, bytes, max_l} <= '0;
         min_l <= '1;
         {stat_frame_count, stat_byte_count, stat_min_len, stat_max_len} <= '0;
         {stat_runt_count, stat_oversize_count, stat_valid} <= '0;
      end else begin
         stat_valid <= snapshot;
         if (snapshot) begin
            stat_frame_count    <= cnt_n;
            stat_byte_count     <= bytes_n;
            stat_min_len        <= |cnt_n ? min_n : '0;
            stat_max_len        <= max_n;
            stat_runt_count     <= runt_n;
            stat_oversize_count <= over_n;
         end
         if (snapshot || clear) begin
            {cnt, runt, over, bytes, max_l} <= '0;
            min_l <= '1;
         end else begin
            cnt   <= cnt_n;
            runt  <= runt_n;
            over  <= over_n;
            bytes <= bytes_n;
            min_l <= min_n;
            max_l <= max_n;
         end
      end
   end
endmodule

// File: tb/tb_axis_frame_len_stats.sv
// tb_axis_frame_len_stats: directed plus random stimulus against a queue-based interval model
module tb_axis_frame_len_stats;
   logic clk = 0, rst = 0, clear = 0, snapshot = 0;
   always #5 clk = ~clk;
   axis_frame_len_stats_if #(.LEN_WIDTH(16)) fl ();
   logic [31:0] fc, rc, oc;
   logic [47:0] bc, bc4;
   logic [15:0] mn, mx, mn4, mx4;
   logic        sv, sv4;
   logic [3:0]  fc4, rc4, oc4;
   axis_frame_len_stats dut (
      .clk(clk), .rst(rst), .fl(fl.slave), .clear(clear), .snapshot(snapshot),
      .stat_frame_count(fc), .stat_byte_count(bc), .stat_min_len(mn), .stat_max_len(mx),
      .stat_runt_count(rc), .stat_oversize_count(oc), .stat_valid(sv));
   axis_frame_len_stats #(.COUNT_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .fl(fl.slave), .clear(clear), .snapshot(snapshot),
      .stat_frame_count(fc4), .stat_byte_count(bc4), .stat_min_len(mn4), .stat_max_len(mx4),
      .stat_runt_count(rc4), .stat_oversize_count(oc4), .stat_valid(sv4));
   int     n_cmp = 0, n_err = 0;
   int     q[$];
   longint e_cnt, e_bytes, e_min, e_max, e_runt, e_over;
   bit     e_valid;
   task automatic chk(input string tag, input longint o, input longint e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, o, e);
      end
   endtask
   function automatic longint sat(input longint x, input longint m);
      return x > m ? m : x;
   endfunction
   // model: the interval is just the list of lengths seen since the last restart
   task automatic cyc(input bit r, input bit v, input int len, input bit c, input bit s);
      rst = r; fl.frame_len_valid = v; fl.frame_len = 16'(len); clear = c; snapshot = s;
      @(posedge clk);
      e_valid = 0;
      if (r) begin
         q.delete();
         {e_cnt, e_bytes, e_min, e_max, e_runt, e_over} = '0;
      end else begin
         if (v) q.push_back(len);
         if (s) begin
            e_valid = 1;
            e_cnt = q.size(); e_bytes = 0; e_runt = 0; e_over = 0;
            e_min = q.size() ? 65535 : 0; e_max = 0;
            foreach (q[i]) begin
               e_bytes += q[i];
               if (q[i] < e_min) e_min = q[i];
               if (q[i] > e_max) e_max = q[i];
               if (q[i] < 64) e_runt++;
               if (q[i] > 1518) e_over++;
            end
         end
         if (s || c) q.delete();
      end
      #1;
      chk("valid", sv, e_valid);
      chk("frames", fc, e_cnt);
      chk("bytes", bc, e_bytes);
      chk("min", mn, e_min);
      chk("max", mx, e_max);
      chk("runt", rc, e_runt);
      chk("over", oc, e_over);
      chk("valid4", sv4, e_valid);
      chk("frames4", fc4, sat(e_cnt, 15));
      chk("bytes4", bc4, e_bytes);
      chk("min4", mn4, e_min);
      chk("max4", mx4, e_max);
      chk("runt4", rc4, sat(e_runt, 15));
      chk("over4", oc4, sat(e_over, 15));
   endtask
   initial begin
      fl.frame_len = 0; fl.frame_len_valid = 0;
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 60, 0, 0);
      cyc(0, 1, 1514, 0, 0);
      cyc(0, 1, 64, 0, 0);
      cyc(0, 1, 2000, 0, 0);
      cyc(0, 0, 0, 0, 1);
      chk("plan_bytes", bc, 3638);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 100, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 1, 500, 0, 0);
      cyc(0, 1, 700, 1, 0);
      cyc(0, 1, 300, 0, 0);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 1, 63, 0, 0);
      cyc(0, 1, 64, 0, 0);
      cyc(0, 1, 1518, 0, 0);
      cyc(0, 1, 1519, 0, 0);
      cyc(0, 1, 65535, 1, 1);
      for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 1, 3000, 0, 0);
      cyc(0, 1, 10, 0, 0);
      cyc(0, 1, 800, 0, 1);
      cyc(0, 1, 40, 0, 0);
      cyc(1, 1, 50, 0, 1);
      cyc(0, 1, 200, 0, 0);
      cyc(0, 0, 0, 0, 1);
      for (int i = 0; i < 400; i++) begin
         int r, len;
         r = $urandom_range(0, 99);
         len = r < 10 ? $urandom_range(0, 65535) : $urandom_range(0, 2100);
         cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, len,
             $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
